// File: rtl/bip_pkg.sv
// Shared BIP definitions: loader FSM encoding, byte width and address sizing helper.
package bip_pkg;

    localparam int NB_BYTE = 8;

    typedef enum logic [2:0] {
        ST_LEN_HI  = 3'd0,
        ST_LEN_LO  = 3'd1,
        ST_CHECK   = 3'd2,
        ST_DATA_HI = 3'd3,
        ST_DATA_LO = 3'd4,
        ST_WRITE   = 3'd5,
        ST_DONE    = 3'd6,
        ST_ERROR   = 3'd7
    } state_e;

    // Number of bits needed to represent value (clogb2(2047) = 11).
    function automatic int clogb2(input int value);
        int v;
        int bits;
        v    = value;
        bits = 0;
        while (v > 0) begin
            bits = bits + 1;
            v    = v >> 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/bip_byte_pair.sv
// Captures a high and a low byte and presents them as one word, plus the word
// as it will look after the captures requested this cycle.
module bip_byte_pair #(
    parameter int NB_BYTE = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_cap_hi,
    input  logic                 i_cap_lo,
    input  logic [NB_BYTE-1:0]   i_data,
    output logic [2*NB_BYTE-1:0] o_word,
    output logic [2*NB_BYTE-1:0] o_word_next
);

    logic [NB_BYTE-1:0] hi_q, hi_d;
    logic [NB_BYTE-1:0] lo_q, lo_d;

    // Byte selection for the capture registers.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (i_cap_hi) begin
            hi_d = i_data;
        end else begin
            hi_d = hi_q;
        end
        if (i_cap_lo) begin
            lo_d = i_data;
        end else begin
            lo_d = lo_q;
        end
    end

    // Capture registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hi_q <= {NB_BYTE{1'b0}};
            lo_q <= {NB_BYTE{1'b0}};
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign o_word      = {hi_q, lo_q};
    assign o_word_next = {hi_d, lo_d};

endmodule

// File: rtl/bip_program_loader.sv
// Loads Program_Memory from a length-prefixed byte stream while holding the CPU
// in reset; releases the CPU once every word has been written.
module bip_program_loader #(
    parameter int NB_BITS       = 16,
    parameter int INS_MEM_DEPTH = 2048,
    parameter int NB_BYTE       = bip_pkg::NB_BYTE,
    parameter int NB_ADDR       = bip_pkg::clogb2(INS_MEM_DEPTH - 1)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NB_BYTE-1:0] i_rx_data,
    input  logic               i_rx_valid,
    output logic               o_rx_ready,
    input  logic               i_reload,
    output logic [NB_ADDR-1:0] o_addr_ins,
    output logic [NB_BITS-1:0] o_data,
    output logic               o_wr,
    output logic               o_cpu_rst,
    output logic               o_done,
    output logic               o_error
);
    import bip_pkg::*;

    localparam logic [NB_BITS-1:0] DEPTH_W = NB_BITS'(INS_MEM_DEPTH);

    state_e             state_q, state_d;
    logic [NB_ADDR-1:0] addr_q, addr_d;
    logic [NB_BITS-1:0] len_q, len_d;
    logic [NB_BITS-1:0] data_q, data_d;
    logic               rdy_q, rdy_d;
    logic               wr_q, wr_d;
    logic               cpu_rst_q, cpu_rst_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               xfer_s;
    logic               cap_hi_s, cap_lo_s;
    logic [NB_BITS-1:0] word_s, word_next_s;

    assign xfer_s = i_rx_valid & rdy_q;

    bip_byte_pair #(
        .NB_BYTE (NB_BYTE)
    ) u_byte_pair (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_cap_hi    (cap_hi_s),
        .i_cap_lo    (cap_lo_s),
        .i_data      (i_rx_data),
        .o_word      (word_s),
        .o_word_next (word_next_s)
    );

    // Next-state, word counter and output register inputs.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        data_d   = data_q;
        wr_d     = 1'b0;
        cap_hi_s = 1'b0;
        cap_lo_s = 1'b0;
        case (state_q)
            ST_LEN_HI: begin
                if (xfer_s) begin
                    cap_hi_s = 1'b1;
                    state_d  = ST_LEN_LO;
                end else begin
                    state_d  = ST_LEN_HI;
                end
            end
            ST_LEN_LO: begin
                if (xfer_s) begin
                    cap_lo_s = 1'b1;
                    state_d  = ST_CHECK;
                end else begin
                    state_d  = ST_LEN_LO;
                end
            end
            ST_CHECK: begin
                len_d = word_s;
                if (word_s == {NB_BITS{1'b0}}) begin
                    state_d = ST_DONE;
                end else if (word_s > DEPTH_W) begin
                    state_d = ST_ERROR;
                end else begin
                    state_d = ST_DATA_HI;
                    addr_d  = {NB_ADDR{1'b0}};
                end
            end
            ST_DATA_HI: begin
                if (xfer_s) begin
                    cap_hi_s = 1'b1;
                    state_d  = ST_DATA_LO;
                end else begin
                    state_d  = ST_DATA_HI;
                end
            end
            ST_DATA_LO: begin
                // The write word includes the byte arriving this cycle.
                if (xfer_s) begin
                    cap_lo_s = 1'b1;
                    wr_d     = 1'b1;
                    data_d   = word_next_s;
                    state_d  = ST_WRITE;
                end else begin
                    state_d  = ST_DATA_LO;
                end
            end
            ST_WRITE: begin
                if (NB_BITS'(addr_q) == (len_q - {{(NB_BITS-1){1'b0}}, 1'b1})) begin
                    state_d = ST_DONE;
                end else begin
                    addr_d  = addr_q + {{(NB_ADDR-1){1'b0}}, 1'b1};
                    state_d = ST_DATA_HI;
                end
            end
            ST_DONE, ST_ERROR: begin
                if (i_reload) begin
                    state_d = ST_LEN_HI;
                    addr_d  = {NB_ADDR{1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_LEN_HI;
                addr_d  = {NB_ADDR{1'b0}};
            end
        endcase

        rdy_d     = (state_d == ST_LEN_HI) || (state_d == ST_LEN_LO) ||
                    (state_d == ST_DATA_HI) || (state_d == ST_DATA_LO);
        cpu_rst_d = (state_d != ST_DONE);
        done_d    = (state_d == ST_DONE);
        err_d     = (state_d == ST_ERROR);
    end

    // State, counter and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_LEN_HI;
            addr_q    <= {NB_ADDR{1'b0}};
            len_q     <= {NB_BITS{1'b0}};
            data_q    <= {NB_BITS{1'b0}};
            rdy_q     <= 1'b0;
            wr_q      <= 1'b0;
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            data_q    <= data_d;
            rdy_q     <= rdy_d;
            wr_q      <= wr_d;
            cpu_rst_q <= cpu_rst_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign o_rx_ready = rdy_q;
    assign o_addr_ins = addr_q;
    assign o_data     = data_q;
    assign o_wr       = wr_q;
    assign o_cpu_rst  = cpu_rst_q;
    assign o_done     = done_q;
    assign o_error    = err_q;

endmodule

// File: tb/tb_bip_program_loader.sv
// Self-checking bench for bip_program_loader: table-driven frames, a write
// scoreboard and hand-written reset/reload/abort sequences.
module tb_bip_program_loader;

    localparam int NB_ADDR = 11;

    logic               clk = 1'b0;
    logic               rst;
    logic [7:0]         rx_data;
    logic               rx_valid;
    logic               rx_ready;
    logic               reload;
    logic [NB_ADDR-1:0] addr_ins;
    logic [15:0]        wdata;
    logic               wr;
    logic               cpu_rst;
    logic               done;
    logic               error;

    int checks = 0;
    int errors = 0;
    int n_writes = 0;
    logic [NB_ADDR-1:0] last_addr = '0;
    logic [NB_ADDR-1:0] exp_addr = '0;
    logic [26:0]        sb_q[$];
    logic [26:0]        mon_e;

    typedef struct {
        logic [15:0] len;
        int          gap;
        logic        exp_err;
    } vec_t;

    vec_t tbl[5];

    always #5 clk = ~clk;

    bip_program_loader #(
        .NB_BITS       (16),
        .INS_MEM_DEPTH (2048)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_rx_data  (rx_data),
        .i_rx_valid (rx_valid),
        .o_rx_ready (rx_ready),
        .i_reload   (reload),
        .o_addr_ins (addr_ins),
        .o_data     (wdata),
        .o_wr       (wr),
        .o_cpu_rst  (cpu_rst),
        .o_done     (done),
        .o_error    (error)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Write monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (wr === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write", addr_ins, wdata);
            end else begin
                mon_e = sb_q.pop_front();
                chk("wr_addr", 32'(addr_ins), 32'(mon_e[26:16]));
                chk("wr_data", 32'(wdata), 32'(mon_e[15:0]));
            end
            chk("cpu_rst_during_wr", 32'(cpu_rst), 32'd1);
            last_addr = addr_ins;
            n_writes++;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        logic sampled;
        int   n;
        while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            rx_valid = 1'b0;
            @(posedge clk); #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        n = 0;
        forever begin
            sampled = rx_ready;
            @(posedge clk); #1;
            if (sampled) break;
            n++;
            if (n > 50) begin
                checks++;
                errors++;
                $display("FAIL byte_timeout: got no ready for byte 0x%0h within 50 cycles expected ready", b);
                break;
            end
        end
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_word(input logic [15:0] w, input int gap_pct);
        send_byte(w[15:8], gap_pct);
        sb_q.push_back({exp_addr, w});
        send_byte(w[7:0], gap_pct);
        chk("wr_latency", 32'(wr), 32'd1);
        exp_addr = exp_addr + 11'd1;
    endtask

    task automatic run_frame(input logic [15:0] len, input int gap_pct, input logic exp_err);
        int w0;
        exp_addr = '0;
        w0 = n_writes;
        send_byte(len[15:8], gap_pct);
        send_byte(len[7:0], gap_pct);
        if (len == 16'd0 || exp_err) begin
            @(posedge clk); #1;
            chk("end_done", 32'(done), exp_err ? 32'd0 : 32'd1);
            chk("end_error", 32'(error), exp_err ? 32'd1 : 32'd0);
            chk("end_cpu_rst", 32'(cpu_rst), exp_err ? 32'd1 : 32'd0);
            chk("end_ready", 32'(rx_ready), 32'd0);
            rx_valid = 1'b1;
            rx_data  = 8'hA5;
            repeat (4) begin @(posedge clk); #1; end
            rx_valid = 1'b0;
            chk("sticky_error", 32'(error), exp_err ? 32'd1 : 32'd0);
            chk("idle_ready", 32'(rx_ready), 32'd0);
            chk("no_writes", 32'(n_writes - w0), 32'd0);
        end else begin
            for (int i = 0; i < int'(len); i++) begin
                send_word(16'($urandom), gap_pct);
            end
            @(posedge clk); #1;
            chk("sb_drained", 32'(sb_q.size()), 32'd0);
            chk("word_count", 32'(n_writes - w0), 32'(len));
            chk("done_after_last", 32'(done), 32'd1);
            chk("cpu_run_after_last", 32'(cpu_rst), 32'd0);
            chk("error_clear", 32'(error), 32'd0);
        end
    endtask

    task automatic do_reload();
        reload = 1'b1;
        @(posedge clk); #1;
        reload = 1'b0;
        chk("reload_done", 32'(done), 32'd0);
        chk("reload_error", 32'(error), 32'd0);
        chk("reload_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("reload_addr", 32'(addr_ins), 32'd0);
        chk("reload_ready", 32'(rx_ready), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish within 2ms");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{len: 16'd0,    gap: 0,  exp_err: 1'b0};
        tbl[1] = '{len: 16'h0801, gap: 0,  exp_err: 1'b1};
        tbl[2] = '{len: 16'd1,    gap: 0,  exp_err: 1'b0};
        tbl[3] = '{len: 16'd7,    gap: 40, exp_err: 1'b0};
        tbl[4] = '{len: 16'hFFFF, gap: 20, exp_err: 1'b1};

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        reload   = 1'b0;

        // Reset values, then ready one cycle after release.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(rx_ready), 32'd0);
        chk("rst_addr", 32'(addr_ins), 32'd0);
        chk("rst_data", 32'(wdata), 32'd0);
        chk("rst_wr", 32'(wr), 32'd0);
        chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_release", 32'(rx_ready), 32'd1);

        // Three-word frame with fixed contents, valid every cycle.
        exp_addr = '0;
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        send_word(16'h1234, 0);
        send_word(16'h5678, 0);
        send_word(16'h9ABC, 0);
        @(posedge clk); #1;
        chk("t2_sb_drained", 32'(sb_q.size()), 32'd0);
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_cpu_rst", 32'(cpu_rst), 32'd0);
        chk("t2_last_addr", 32'(last_addr), 32'd2);
        do_reload();

        for (int k = 0; k < 5; k++) begin
            run_frame(tbl[k].len, tbl[k].gap, tbl[k].exp_err);
            do_reload();
        end

        // Full-depth frame with random valid gaps.
        run_frame(16'd2048, 50, 1'b0);
        chk("full_last_addr", 32'(last_addr), 32'h7FF);
        do_reload();

        // Abort a 10-word frame after 5 words, then load a 2-word frame.
        exp_addr = '0;
        send_byte(8'h00, 0);
        send_byte(8'h0A, 0);
        for (int i = 0; i < 5; i++) begin
            send_word(16'($urandom), 0);
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_addr", 32'(addr_ins), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("abort_sb", 32'(sb_q.size()), 32'd0);
        run_frame(16'd2, 0, 1'b0);
        chk("restart_last_addr", 32'(last_addr), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
